// File: rtl/alarm_playback_sequencer_pkg.sv
// Shared types and constants for the alarm clip playback sequencer.
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        WAIT,
        GAP,
        SNOOZE
    } state_e;

    localparam int SAMPLE_W    = 16;
    localparam int Q_FRAC_BITS = 14;  // samples are signed Q2.14
    localparam logic [SAMPLE_W-1:0] SILENCE = '0;

    localparam int CLK_HZ         = 50_000_000;
    localparam int SAMPLE_HZ      = 8000;
    localparam int SAMPLE_DIV_DEF = CLK_HZ / SAMPLE_HZ;

    // States in which the modulator must hear silence
    function automatic logic is_silent(input state_e s);
        return (s == IDLE) || (s == GAP) || (s == SNOOZE);
    endfunction

    function automatic logic is_playing(input state_e s);
        return (s == FETCH) || (s == LATCH) || (s == WAIT) || (s == GAP);
    endfunction

endpackage

// File: rtl/alarm_playback_sequencer_if.sv
// Sample ROM read bus between the sequencer (master) and the clip ROM (slave).
interface alarm_playback_sequencer_if
    import alarm_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = SAMPLE_W
);
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_rd, output rom_addr, input rom_data);
    modport slave  (input rom_rd, input rom_addr, output rom_data);
endinterface

// File: rtl/alarm_playback_sequencer_ms_event_counter.sv
// Counts ms_tick pulses while enabled and pulses done on the load-th one.
module ms_event_counter
    import alarm_pkg::*;
#(
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             tick,
    input  logic [CNT_W-1:0] load,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        done  = enable && tick && (cnt_q == load - CNT_W'(1));
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && tick) begin
            cnt_d = done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_playback_sequencer.sv
// Plays the alarm clip from the sample ROM at the audio rate, with repeats,
// silent gaps, snooze and dismiss handling.
module alarm_playback_sequencer
    import alarm_pkg::*;
#(
    parameter int CLIP_LEN   = 19832,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = SAMPLE_W,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int REPEATS    = 3,
    parameter int GAP_MS     = 500,
    parameter int SNOOZE_MS  = 300000
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         alarm_match,
    input  logic                         ms_tick,
    input  logic                         snooze,
    input  logic                         dismiss,
    alarm_playback_sequencer_if.master   rom,
    output logic [DATA_W-1:0]            sample_out,
    output logic                         sample_valid,
    output logic                         playing,
    output logic                         snoozed
);
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int REP_W  = $clog2(REPEATS + 1);
    localparam int MS_MAX = (GAP_MS > SNOOZE_MS) ? GAP_MS : SNOOZE_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);

    state_e            state_q, state_d;
    logic              match_q, match_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              eoc_q, eoc_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              pulse_q, pulse_d;

    logic              start;
    logic              latch_take;
    logic [DATA_W-1:0] sample_now;
    logic              ms_clear, ms_en, ms_done;
    logic [MS_W-1:0]   ms_load;

    assign start      = alarm_match & ~match_q;
    assign match_d    = alarm_match;
    // The ROM word is shown in LATCH itself; a concurrent snooze or dismiss discards it
    assign latch_take = (state_q == LATCH) && !snooze && !dismiss;
    assign sample_now = latch_take ? rom.rom_data : sample_q;

    assign ms_en   = (state_q == GAP) || (state_q == SNOOZE);
    assign ms_load = (state_q == SNOOZE) ? MS_W'(SNOOZE_MS) : MS_W'(GAP_MS);

    ms_event_counter #(
        .CNT_W (MS_W)
    ) u_ms_cnt (
        .clk    (CLOCK_50),
        .rst    (reset),
        .clear  (ms_clear),
        .enable (ms_en),
        .tick   (ms_tick),
        .load   (ms_load),
        .done   (ms_done)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rep_d    = rep_q;
        div_d    = div_q;
        eoc_d    = eoc_q;
        sample_d = sample_q;
        pulse_d  = 1'b0;
        ms_clear = 1'b0;

        if (dismiss) begin
            state_d  = IDLE;
            addr_d   = '0;
            rep_d    = '0;
            div_d    = '0;
            eoc_d    = 1'b0;
            ms_clear = 1'b1;
        end else if (snooze && is_playing(state_q)) begin
            state_d  = SNOOZE;
            div_d    = '0;
            eoc_d    = 1'b0;
            ms_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_d  = '0;
                        rep_d   = '0;
                        state_d = FETCH;
                    end
                end
                FETCH: state_d = LATCH;
                LATCH: begin
                    sample_d = rom.rom_data;
                    div_d    = DIV_W'(SAMPLE_DIV - 3);
                    state_d  = WAIT;
                    if (addr_q == ADDR_W'(CLIP_LEN - 1)) begin
                        addr_d = '0;
                        rep_d  = rep_q + REP_W'(1);
                        eoc_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                WAIT: begin
                    if (div_q != '0) begin
                        div_d = div_q - DIV_W'(1);
                    end else if (!eoc_q) begin
                        state_d = FETCH;
                    end else begin
                        eoc_d = 1'b0;
                        if (rep_q < REP_W'(REPEATS)) begin
                            state_d  = GAP;
                            ms_clear = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                GAP: begin
                    if (ms_done) begin
                        addr_d  = '0;
                        state_d = FETCH;
                    end
                end
                SNOOZE: begin
                    if (ms_done) begin
                        rep_d   = '0;
                        addr_d  = '0;
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Entering a silent state mutes the output, announcing it only if it was audible
        if (is_silent(state_d)) begin
            sample_d = DATA_W'(SILENCE);
            pulse_d  = (sample_now != DATA_W'(SILENCE));
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            match_q  <= 1'b1;
            addr_q   <= '0;
            rep_q    <= '0;
            div_q    <= '0;
            eoc_q    <= 1'b0;
            sample_q <= DATA_W'(SILENCE);
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            addr_q   <= addr_d;
            rep_q    <= rep_d;
            div_q    <= div_d;
            eoc_q    <= eoc_d;
            sample_q <= sample_d;
            pulse_q  <= pulse_d;
        end
    end

    assign rom.rom_rd   = (state_q == FETCH);
    assign rom.rom_addr = addr_q;
    assign sample_out   = sample_now;
    assign sample_valid = latch_take | pulse_q;
    assign playing      = is_playing(state_q);
    assign snoozed      = (state_q == SNOOZE);

endmodule
